// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_sched_pkg
// Brief   : Shared defaults, id-width helper and types for adder_rr_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package adder_sched_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_N_REQ  = 4;
    localparam int RBUF_DEPTH = 2;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W = id_width(DEF_N_REQ);

    // Result entry layout for the default configuration
    typedef struct packed {
        logic [DEF_WIDTH:0]  sum;
        logic [DEF_ID_W-1:0] id;
    } rbuf_entry_t;

    typedef enum logic [0:0] {
        SCHED_IDLE = 1'b0,
        SCHED_BUSY = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/adder_rr_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : N-way round-robin arbiter, one-hot grant, pointer advances past
//           the winner on every grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int N     = DEF_N_REQ,
    parameter int IDX_W = id_width(DEF_N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    int               w_sum;

    // Scan from farthest to nearest so the candidate closest to r_ptr wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_sum       = 0;
        w_cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_cand = IDX_W'(w_sum);
            if (i_en && i_req[w_cand]) begin
                o_grant         = '0;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|o_grant) begin
            r_ptr <= (o_grant_idx == IDX_W'(N - 1)) ? '0 : o_grant_idx + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : adder_rr_scheduler
// Brief   : Shares one external sync adder between N requesters with
//           round-robin issue and a 2-entry tagged result buffer.
// Revision: 1.0 - initial release
// ============================================================================
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH:0]         rsp_sum,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   add_enable,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH:0]         add_sum,
    input  logic                   add_valid,
    output logic                   proto_err
);

    typedef struct packed {
        logic [WIDTH:0]  sum;
        logic [ID_W-1:0] id;
    } entry_t;

    entry_t       r_buf [RBUF_DEPTH];
    logic [1:0]   r_cnt;
    sched_state_t r_state;
    logic [ID_W-1:0] r_id_q;
    logic         r_proto;

    logic         w_inflight;
    logic         w_pop;
    logic         w_push;
    logic [2:0]   w_occ;
    logic         w_can_issue;
    logic [ID_W-1:0] w_grant_idx;
    entry_t       w_new;

    assign w_inflight = (r_state == SCHED_BUSY);
    assign rsp_valid  = rst_n & (r_cnt != 2'd0);
    assign w_pop      = rsp_valid & rsp_ready;
    assign w_push     = add_valid & w_inflight;

    // Counting the in-flight result up front guarantees it always has a slot
    assign w_occ       = {1'b0, r_cnt} + {2'b0, w_inflight} - {2'b0, w_pop};
    assign w_can_issue = rst_n & (w_occ < 3'(RBUF_DEPTH));

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_can_issue),
        .i_req       (req_valid),
        .o_grant     (req_ready),
        .o_grant_idx (w_grant_idx)
    );

    assign add_enable = |req_ready;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                add_a = req_a[i*WIDTH +: WIDTH];
                add_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_new     = '{sum: add_sum, id: r_id_q};
    assign rsp_sum   = r_buf[0].sum;
    assign rsp_id    = r_buf[0].id;
    assign proto_err = r_proto;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SCHED_IDLE;
            r_id_q  <= '0;
            r_cnt   <= 2'd0;
            r_proto <= 1'b0;
        end else begin
            r_state <= add_enable ? SCHED_BUSY : SCHED_IDLE;
            if (add_enable) begin
                r_id_q <= w_grant_idx;
            end
            if (add_valid && !w_inflight) begin
                r_proto <= 1'b1;
            end
            // Entry 0 is always the head; a pop shifts entry 1 forward
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_buf[0] <= w_new;
                    end else begin
                        r_buf[1] <= w_new;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_cnt    <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_buf[0] <= w_new;
                    end else begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_rr_scheduler
// Brief   : Self-checking bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_rr_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W:0]     rsp_sum;
    logic [1:0]     rsp_id;
    logic           add_enable;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W:0]     add_sum;
    logic           add_valid;
    logic           proto_err;

    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];
    logic           force_v;
    logic           adder_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_arr[i];
            req_b[i*W +: W] = b_arr[i];
        end
    end

    // Behavioural sync adder sitting beside the scheduler
    always @(posedge clk) begin
        if (!rst_n) begin
            adder_v <= 1'b0;
            add_sum <= '0;
        end else if (add_enable) begin
            add_sum <= {1'b0, add_a} + {1'b0, add_b};
            adder_v <= 1'b1;
        end else begin
            adder_v <= 1'b0;
        end
    end
    assign add_valid = adder_v | force_v;

    adder_rr_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .add_enable(add_enable), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_valid(add_valid),
        .proto_err(proto_err)
    );

    // Reference model: results waiting in the buffer, plus the one in the adder
    typedef struct {
        logic [W:0] sum;
        int         id;
    } ent_t;

    ent_t       m_buf[$];
    bit         m_infl;
    ent_t       m_infl_e;
    int         m_ptr;
    bit         m_proto;

    function automatic int model_grant();
        int occ;
        occ = m_buf.size() + (m_infl ? 1 : 0) - ((m_buf.size() > 0 && rsp_ready) ? 1 : 0);
        if (!rst_n || occ >= 2) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance one clock
    task automatic step();
        int g;
        bit pop;
        #1;
        g   = model_grant();
        pop = rst_n && m_buf.size() > 0 && rsp_ready;
        chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("add_enable", add_enable, (g >= 0) ? 32'd1 : 32'd0);
        chk("add_a", add_a, (g >= 0) ? 32'(a_arr[g]) : 32'd0);
        chk("add_b", add_b, (g >= 0) ? 32'(b_arr[g]) : 32'd0);
        chk("rsp_valid", rsp_valid, (rst_n && m_buf.size() > 0) ? 32'd1 : 32'd0);
        if (rst_n && m_buf.size() > 0) begin
            chk("rsp_sum", rsp_sum, 32'(m_buf[0].sum));
            chk("rsp_id", rsp_id, 32'(m_buf[0].id));
        end
        chk("proto_err", proto_err, 32'(m_proto));
        @(posedge clk);
        if (!rst_n) begin
            m_buf.delete();
            m_infl  = 1'b0;
            m_ptr   = 0;
            m_proto = 1'b0;
        end else begin
            if (pop) m_buf.delete(0);
            if (m_infl) m_buf.push_back(m_infl_e);
            else if (force_v) m_proto = 1'b1;
            m_infl = (g >= 0);
            if (g >= 0) begin
                m_infl_e.sum = {1'b0, a_arr[g]} + {1'b0, b_arr[g]};
                m_infl_e.id  = g;
                m_ptr        = (g + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int id;
        int a;
        int b;
        int sum;
    } vec_t;

    vec_t vt [6];
    logic [W:0] head_sum;
    logic [1:0] head_id;

    initial begin
        vt[0] = '{0, 15, 25, 40};
        vt[1] = '{3, 255, 255, 510};
        vt[2] = '{2, 200, 100, 300};
        vt[3] = '{1, 0, 0, 0};
        vt[4] = '{1, 128, 128, 256};
        vt[5] = '{0, 1, 254, 255};

        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        force_v   = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 8'(i + 1);
            b_arr[i] = 8'(i + 2);
        end
        m_infl = 1'b0; m_ptr = 0; m_proto = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, with requests pending
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_add_enable", add_enable, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_proto_err", proto_err, 0);
        req_valid = '0;
        do_reset();

        // Directed single requests, including carry-out cases
        for (int v = 0; v < 6; v++) begin
            req_valid = 4'(1 << vt[v].id);
            a_arr[vt[v].id] = 8'(vt[v].a);
            b_arr[vt[v].id] = 8'(vt[v].b);
            #1 chk("vec_ready", req_ready, 32'd1 << vt[v].id);
            step();
            req_valid = '0;
            #1;
            chk("vec_ready_once", req_ready, 0);
            chk("vec_not_yet", rsp_valid, 0);
            step();
            #1;
            chk("vec_valid", rsp_valid, 1);
            chk("vec_sum", rsp_sum, vt[v].sum);
            chk("vec_id", rsp_id, vt[v].id);
            step();
        end

        // Fairness: all requesters hold valid, one response per cycle
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 8'(10 * i + 1);
            b_arr[i] = 8'(i + 3);
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1 chk("fair_grant", req_ready, 32'd1 << (k % N));
            if (k >= 2) begin
                chk("fair_rsp_valid", rsp_valid, 1);
                chk("fair_rsp_id", rsp_id, (k - 2) % N);
            end
            step();
        end

        // Backpressure: buffer fills, issue stops, head holds
        rsp_ready = 1'b0;
        #1;
        head_sum = rsp_sum;
        head_id  = rsp_id;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("bp_ready_zero", req_ready, 0);
            chk("bp_head_sum", rsp_sum, 32'(head_sum));
            chk("bp_head_id", rsp_id, 32'(head_id));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
        #1 chk("bp_drained", rsp_valid, 0);

        // Reset with one result buffered and one in the adder
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("no_stale_rsp", rsp_valid, 0);
            step();
        end
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        req_valid = 4'hF;
        #1 chk("post_rst_ptr", req_ready, 1);
        step();
        req_valid = '0;
        step();
        #1;
        chk("post_rst_valid", rsp_valid, 1);
        chk("post_rst_sum", rsp_sum, 0);
        chk("post_rst_id", rsp_id, 0);
        step();

        // Spurious adder valid sets a sticky error and pushes nothing
        step();
        force_v = 1'b1;
        step();
        force_v = 1'b0;
        #1;
        chk("proto_set", proto_err, 1);
        chk("proto_no_push", rsp_valid, 0);
        repeat (3) step();
        #1 chk("proto_sticky", proto_err, 1);
        do_reset();
        #1 chk("proto_cleared", proto_err, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                a_arr[i] = 8'($urandom);
                b_arr[i] = 8'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
        #1 chk("rand_drained", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
